// File: rtl/ppu_pixel_mux.sv
// Per-pixel output stage: merges the scrolled background with two sprites,
// resolves priority, registers one colour per pixel and tracks sprite-0 hit.
module ppu_pixel_mux (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_en,
    input  logic        line_start,
    input  logic [2:0]  fine_x,
    input  logic        bg_enable,
    input  logic        spr_enable,
    input  logic        bg_load,
    input  logic [7:0]  bg_pattern_lo,
    input  logic [7:0]  bg_pattern_hi,
    input  logic [31:0] bg_colors,
    input  logic [7:0]  backdrop_color,
    input  logic [7:0]  spr0_x,
    input  logic [7:0]  spr1_x,
    input  logic [7:0]  spr0_pattern_lo,
    input  logic [7:0]  spr0_pattern_hi,
    input  logic [7:0]  spr1_pattern_lo,
    input  logic [7:0]  spr1_pattern_hi,
    input  logic [31:0] spr0_colors,
    input  logic [31:0] spr1_colors,
    input  logic        spr0_behind,
    input  logic        spr1_behind,
    input  logic        spr0_valid,
    input  logic        spr1_valid,
    input  logic        hit_clear,
    output logic [7:0]  pixel_color,
    output logic        pixel_valid,
    output logic        sprite0_hit
);

    // Pixel stream: every pixel_en cycle not claimed by line_start produces
    // exactly one pixel_valid pulse one cycle later; there is no back-pressure.
    logic        pix_go;
    logic [7:0]  pixel_x;

    logic [15:0] bg_lo, bg_hi, tag;
    logic [31:0] hi_pal, lo_pal;
    logic [3:0]  bit_sel;
    logic [1:0]  bg_idx;
    logic [31:0] bg_pal;
    logic        bg_opaque;

    logic [1:0][7:0]  in_x, in_lo, in_hi;
    logic [1:0][31:0] in_col;
    logic [1:0]       in_behind, in_valid;

    logic [1:0][7:0]  spr_xcnt, spr_lo, spr_hi;
    logic [1:0][31:0] spr_col;
    logic [1:0]       spr_behind, spr_valid;
    logic [1:0][3:0]  spr_cnt;
    logic [1:0]       spr_emit, spr_opaque;
    logic [1:0][1:0]  spr_idx;

    logic        spr_win;
    logic [1:0]  win_idx;
    logic [31:0] win_col;
    logic        win_behind;
    logic [7:0]  color;
    logic        hit_set;

    assign pix_go    = pixel_en & ~line_start;
    assign in_x      = {spr1_x, spr0_x};
    assign in_lo     = {spr1_pattern_lo, spr0_pattern_lo};
    assign in_hi     = {spr1_pattern_hi, spr0_pattern_hi};
    assign in_col    = {spr1_colors, spr0_colors};
    assign in_behind = {spr1_behind, spr0_behind};
    assign in_valid  = {spr1_valid, spr0_valid};

    // Fine-X picks which of the 16 window bits is the current pixel.
    assign bit_sel   = 4'd15 - {1'b0, fine_x};
    assign bg_idx    = {bg_hi[bit_sel], bg_lo[bit_sel]};
    assign bg_pal    = tag[bit_sel] ? lo_pal : hi_pal;
    assign bg_opaque = bg_enable & (bg_idx != 2'b00);

    always_comb begin
        spr_emit   = '0;
        spr_idx    = '0;
        spr_opaque = '0;
        for (int k = 0; k < 2; k++) begin
            spr_emit[k]   = spr_valid[k] && (spr_xcnt[k] == 8'd0) && (spr_cnt[k] < 4'd8);
            spr_idx[k]    = spr_emit[k] ? {spr_hi[k][7], spr_lo[k][7]} : 2'b00;
            spr_opaque[k] = spr_enable && (spr_idx[k] != 2'b00);
        end
    end

    always_comb begin
        spr_win    = spr_opaque[0] | spr_opaque[1];
        win_idx    = spr_opaque[0] ? spr_idx[0] : spr_idx[1];
        win_col    = spr_opaque[0] ? spr_col[0] : spr_col[1];
        win_behind = spr_opaque[0] ? spr_behind[0] : spr_behind[1];
        color      = backdrop_color;
        if (spr_win && (!win_behind || !bg_opaque)) begin
            color = win_col[{win_idx, 3'b000} +: 8];
        end else if (bg_opaque) begin
            color = bg_pal[{bg_idx, 3'b000} +: 8];
        end
    end

    assign hit_set = pix_go & spr_opaque[0] & bg_opaque & (pixel_x != 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_lo  <= '0;
            bg_hi  <= '0;
            tag    <= '0;
            hi_pal <= '0;
            lo_pal <= '0;
        end else if (pix_go) begin
            if (bg_load) begin
                bg_lo  <= {bg_lo[14:7], bg_pattern_lo};
                bg_hi  <= {bg_hi[14:7], bg_pattern_hi};
                tag    <= 16'h00FF;
                hi_pal <= lo_pal;
                lo_pal <= bg_colors;
            end else begin
                bg_lo <= {bg_lo[14:0], 1'b0};
                bg_hi <= {bg_hi[14:0], 1'b0};
                tag   <= {tag[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_xcnt   <= '0;
            spr_lo     <= '0;
            spr_hi     <= '0;
            spr_col    <= '0;
            spr_behind <= '0;
            spr_valid  <= '0;
            spr_cnt    <= '0;
        end else if (line_start) begin
            spr_xcnt   <= in_x;
            spr_lo     <= in_lo;
            spr_hi     <= in_hi;
            spr_col    <= in_col;
            spr_behind <= in_behind;
            spr_valid  <= in_valid;
            spr_cnt    <= '0;
        end else if (pixel_en) begin
            for (int k = 0; k < 2; k++) begin
                if (spr_valid[k] && (spr_xcnt[k] != 8'd0)) begin
                    spr_xcnt[k] <= spr_xcnt[k] - 8'd1;
                end else if (spr_emit[k]) begin
                    spr_lo[k]  <= {spr_lo[k][6:0], 1'b0};
                    spr_hi[k]  <= {spr_hi[k][6:0], 1'b0};
                    spr_cnt[k] <= spr_cnt[k] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_color <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            sprite0_hit <= 1'b0;
        end else begin
            pixel_valid <= pix_go;
            if (pix_go) begin
                pixel_color <= color;
            end
            if (line_start) begin
                pixel_x <= '0;
            end else if (pixel_en) begin
                pixel_x <= pixel_x + 8'd1;
            end
            if (hit_clear) begin
                sprite0_hit <= 1'b0;
            end else if (hit_set) begin
                sprite0_hit <= 1'b1;
            end
        end
    end

endmodule
